mcu_wb_arbiter: RTL

- Write-back arbiter that is the driving end of the integer register file write port (we/waddr/wdata).
- Merges single-cycle ALU results with variable-latency LSU load responses into the one register-file write per cycle.
- Keeps a per-register pending-load busy mask so the issue stage can stall on RAW and WAW hazards.
- Sits between the execute/LSU stages and the register file of the control processor.

---
 rtl/mcu_wb_arbiter_if.sv | 39 +++
 rtl/mcu_wb_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mcu_wb_arbiter_if.sv
// Write-back arbiter bus: execute/LSU/issue inputs on one side,
// register-file write port and hazard status on the other.
interface mcu_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            issue_load_valid;
    logic [4:0]      issue_load_rd;
    logic [31:0]     busy_mask;
    logic            alu_stall;
    logic            err_waw;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    // Arbiter side: drives the register-file write port and status.
    modport master (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_load_valid, issue_load_rd,
        output lsu_ready, busy_mask, alu_stall, err_waw,
        output rf_we, rf_waddr, rf_wdata
    );

    // Pipeline side: presents results and observes the arbiter.
    modport slave (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_load_valid, issue_load_rd,
        input  lsu_ready, busy_mask, alu_stall, err_waw,
        input  rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/mcu_wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results with buffered
// load responses into one register-file write per cycle, and tracks
// per-register pending loads for the issue stage.
module mcu_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mcu_wb_arbiter_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Load-response buffer storage and bookkeeping
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [4:0]      mem_rd   [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;

    logic            full;
    logic            empty;
    logic            accept;
    logic            push;
    logic            pop;

    // Winner of this cycle's write-port slot
    logic            sel_valid;
    logic            sel_load;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    logic [SW-1:0]   starve;
    logic [SW-1:0]   starve_next;
    logic [31:0]     busy_q;
    logic [31:0]     busy_next;
    logic            stall_q;
    logic            stall_next;
    logic            err_q;
    logic            err_next;

    logic            rf_we_q;
    logic [4:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // lsu_ready is a pure function of buffer state, never of alu_valid
    assign bus.lsu_ready = !full;
    assign bus.busy_mask = busy_q;
    assign bus.alu_stall = stall_q;
    assign bus.err_waw   = err_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;

    // Priority selection: ALU, then buffered head, then bypass of a fresh load
    always_comb begin
        accept    = bus.lsu_valid && !full;
        push      = 1'b0;
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_load  = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (bus.alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.alu_rd;
            sel_data  = bus.alu_data;
            push      = accept;
        end else if (!empty) begin
            pop       = 1'b1;
            push      = accept;
            sel_valid = 1'b1;
            sel_load  = 1'b1;
            sel_rd    = mem_rd[rd_ptr];
            sel_data  = mem_data[rd_ptr];
        end else if (accept) begin
            sel_valid = 1'b1;
            sel_load  = 1'b1;
            sel_rd    = bus.lsu_rd;
            sel_data  = bus.lsu_data;
        end
    end

    // Next-state for occupancy, starvation, busy mask, stall and error
    always_comb begin
        count_next = count + CW'(push) - CW'(pop);

        starve_next = starve;
        if (pop || empty) begin
            starve_next = '0;
        end else if (bus.alu_valid && (starve != SW'(STARVE_LIMIT))) begin
            starve_next = starve + SW'(1);
        end

        // Clear for the retiring load first so a same-cycle issue wins
        busy_next = busy_q;
        if (sel_load) begin
            busy_next[sel_rd] = 1'b0;
        end
        if (bus.issue_load_valid && (bus.issue_load_rd != 5'd0)) begin
            busy_next[bus.issue_load_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;

        stall_next = (count_next == CW'(DEPTH)) || (starve_next == SW'(STARVE_LIMIT));

        err_next = err_q;
        if (bus.alu_valid &&
            (((bus.alu_rd != 5'd0) && busy_q[bus.alu_rd]) || stall_q)) begin
            err_next = 1'b1;
        end
    end

    // Buffer payload storage; contents are don't-care while not counted
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= bus.lsu_data;
            mem_rd[wr_ptr]   <= bus.lsu_rd;
        end
    end

    // Buffer pointers and occupancy; power-of-two depth wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

    // Hazard and flow-control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve  <= '0;
            busy_q  <= '0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            starve  <= starve_next;
            busy_q  <= busy_next;
            stall_q <= stall_next;
            err_q   <= err_next;
        end
    end

    // Registered write port; writes to x0 are consumed but leave address/data held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid && (sel_rd != 5'd0)) begin
                rf_waddr_q <= sel_rd;
                rf_wdata_q <= sel_data;
            end
        end
    end
endmodule
